// File: rtl/stopwatch_core_if.sv
// Control and display bundle between the button logic, the stopwatch core and the 7-segment mux.
interface stopwatch_core_if;
  logic        stop;
  logic        clear;
  logic        load;
  logic [15:0] preset;
  logic        mode;
  logic        lap;
  logic [3:0]  num1;
  logic [3:0]  num2;
  logic [3:0]  num3;
  logic [3:0]  num4;
  logic        tick;
  logic        wrapped;
  logic        done;

  modport master (
    output stop, clear, load, preset, mode, lap,
    input  num1, num2, num3, num4, tick, wrapped, done
  );

  modport slave (
    input  stop, clear, load, preset, mode, lap,
    output num1, num2, num3, num4, tick, wrapped, done
  );
endinterface

// File: rtl/stopwatch_core.sv
// Single-clock BCD stopwatch/timer: tenth-second prescaler, up/down digit chain,
// preset load, clear and lap display hold.
module stopwatch_core #(
  parameter int TICK_DIV = 250000,
  parameter int DIV_W    = 18,
  parameter int MIN_MAX  = 9
) (
  input  logic             clk_base,
  input  logic             reset,
  stopwatch_core_if.slave  bus
);

  localparam logic [3:0]       MIN_TOP = 4'(MIN_MAX);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(TICK_DIV - 1);

  typedef enum logic {LIVE, HOLD} hold_t;

  hold_t            hold_state, hold_next;
  logic [15:0]      cnt, cnt_up, cnt_dn, preset_c, lap_reg, disp;
  logic [DIV_W-1:0] div_cnt;
  logic             halted, running, tick_int, at_max, capture;
  logic             done_q, tick_q, wrap_q;

  assign halted   = bus.mode && (cnt == '0);
  assign running  = !bus.stop && !halted;
  assign tick_int = running && (div_cnt == DIV_TOP);
  assign at_max   = (cnt == {MIN_TOP, 4'd5, 4'd9, 4'd9});

  // Carry chain; the all-digits-at-max case falls through to zero (rollover).
  always_comb begin
    cnt_up = '0;
    if (cnt[3:0] != 4'd9)         cnt_up = {cnt[15:4], cnt[3:0] + 4'd1};
    else if (cnt[7:4] != 4'd9)    cnt_up = {cnt[15:8], cnt[7:4] + 4'd1, 4'd0};
    else if (cnt[11:8] != 4'd5)   cnt_up = {cnt[15:12], cnt[11:8] + 4'd1, 8'd0};
    else if (cnt[15:12] != MIN_TOP) cnt_up = {cnt[15:12] + 4'd1, 12'd0};
  end

  always_comb begin
    cnt_dn = cnt;
    if (cnt[3:0] != 4'd0)         cnt_dn = {cnt[15:4], cnt[3:0] - 4'd1};
    else if (cnt[7:4] != 4'd0)    cnt_dn = {cnt[15:8], cnt[7:4] - 4'd1, 4'd9};
    else if (cnt[11:8] != 4'd0)   cnt_dn = {cnt[15:12], cnt[11:8] - 4'd1, 8'h99};
    else if (cnt[15:12] != 4'd0)  cnt_dn = {cnt[15:12] - 4'd1, 12'h599};
  end

  always_comb begin
    preset_c[3:0]   = (bus.preset[3:0]   > 4'd9)   ? 4'd9   : bus.preset[3:0];
    preset_c[7:4]   = (bus.preset[7:4]   > 4'd9)   ? 4'd9   : bus.preset[7:4];
    preset_c[11:8]  = (bus.preset[11:8]  > 4'd5)   ? 4'd5   : bus.preset[11:8];
    preset_c[15:12] = (bus.preset[15:12] > MIN_TOP) ? MIN_TOP : bus.preset[15:12];
  end

  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      div_cnt <= '0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.clear) begin
        cnt     <= '0;
        div_cnt <= '0;
        done_q  <= 1'b0;
      end else if (bus.load) begin
        cnt     <= preset_c;
        div_cnt <= '0;
        done_q  <= 1'b0;
      end else begin
        if (running)
          div_cnt <= (div_cnt == DIV_TOP) ? '0 : div_cnt + 1'b1;
        if (tick_int) begin
          tick_q <= 1'b1;
          if (bus.mode) begin
            cnt <= cnt_dn;
          end else begin
            cnt    <= cnt_up;
            wrap_q <= at_max;
          end
        end
        if (!bus.mode)
          done_q <= 1'b0;
        else if (halted || (tick_int && cnt_dn == '0))
          done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) hold_state <= LIVE;
    else       hold_state <= hold_next;
  end

  always_comb begin
    hold_next = hold_state;
    capture   = 1'b0;
    if (bus.clear) begin
      hold_next = LIVE;
    end else if (bus.lap) begin
      if (hold_state == LIVE) begin
        hold_next = HOLD;
        capture   = 1'b1;
      end else begin
        hold_next = LIVE;
      end
    end
  end

  always_ff @(posedge clk_base or posedge reset) begin
    if (reset)         lap_reg <= '0;
    else if (bus.clear) lap_reg <= '0;
    else if (capture)  lap_reg <= cnt;
  end

  assign disp        = (hold_state == HOLD) ? lap_reg : cnt;
  assign bus.num1    = disp[15:12];
  assign bus.num2    = disp[11:8];
  assign bus.num3    = disp[7:4];
  assign bus.num4    = disp[3:0];
  assign bus.tick    = tick_q;
  assign bus.wrapped = wrap_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: reference model keeps the count as total tenths.
module tb_stopwatch_core;
  localparam int TD   = 4;
  localparam int MM   = 9;
  localparam int MAXT = MM * 600 + 599;

  typedef struct packed {
    logic [3:0] n1, n2, n3, n4;
    logic       tk, wr, dn;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  stopwatch_core_if ifc();

  stopwatch_core #(.TICK_DIV(TD), .DIV_W(3), .MIN_MAX(MM)) dut (
    .clk_base (clk),
    .reset    (reset),
    .bus      (ifc)
  );

  always #5 clk = ~clk;

  obs_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_t, m_ph, m_lap;
  bit   m_done, m_hold;
  int   tick_cnt, wrap_cnt;

  function automatic obs_t make_obs(bit tk, bit wr);
    obs_t o;
    int   v;
    v    = m_hold ? m_lap : m_t;
    o.n1 = 4'(v / 600);
    o.n2 = 4'((v % 600) / 100);
    o.n3 = 4'((v % 100) / 10);
    o.n4 = 4'(v % 10);
    o.tk = tk;
    o.wr = wr;
    o.dn = m_done;
    return o;
  endfunction

  function automatic int clamp_tenths(logic [15:0] p);
    int mi, te, un, tn;
    mi = (p[15:12] > MM) ? MM : int'(p[15:12]);
    te = (p[11:8] > 5) ? 5 : int'(p[11:8]);
    un = (p[7:4] > 9) ? 9 : int'(p[7:4]);
    tn = (p[3:0] > 9) ? 9 : int'(p[3:0]);
    return mi * 600 + te * 100 + un * 10 + tn;
  endfunction

  function automatic int disp();
    return int'({ifc.num1, ifc.num2, ifc.num3, ifc.num4});
  endfunction

  task automatic model_reset();
    m_t = 0; m_ph = 0; m_lap = 0; m_done = 1'b0; m_hold = 1'b0;
  endtask

  task automatic check(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply current inputs to the model, queue the expected response, then clock the DUT.
  task automatic cycle();
    int t_old;
    bit halted, fire, tk, wr;
    t_old  = m_t;
    halted = ifc.mode && (m_t == 0);
    fire   = !ifc.stop && !halted && (m_ph == TD - 1);
    tk = 1'b0; wr = 1'b0;
    if (ifc.clear) begin
      m_t = 0; m_ph = 0; m_done = 1'b0;
    end else if (ifc.load) begin
      m_t = clamp_tenths(ifc.preset); m_ph = 0; m_done = 1'b0;
    end else begin
      if (!ifc.stop && !halted) m_ph = (m_ph + 1) % TD;
      if (fire) begin
        tk = 1'b1;
        if (ifc.mode) m_t = m_t - 1;
        else begin
          wr  = (m_t == MAXT);
          m_t = (m_t + 1) % (MAXT + 1);
        end
      end
      m_done = ifc.mode ? (m_done || (m_t == 0)) : 1'b0;
    end
    if (ifc.clear) begin
      m_hold = 1'b0; m_lap = 0;
    end else if (ifc.lap) begin
      if (!m_hold) begin m_lap = t_old; m_hold = 1'b1; end
      else m_hold = 1'b0;
    end
    sb_q.push_back(make_obs(tk, wr));
    @(posedge clk);
    #1;
    if (ifc.tick)    tick_cnt++;
    if (ifc.wrapped) wrap_cnt++;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  always @(negedge clk) begin
    obs_t exp, act;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      act = {ifc.num1, ifc.num2, ifc.num3, ifc.num4, ifc.tick, ifc.wrapped, ifc.done};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL scoreboard at %0t: got num=%h%h%h%h tick=%b wrap=%b done=%b, want num=%h%h%h%h tick=%b wrap=%b done=%b",
                 $time, act.n1, act.n2, act.n3, act.n4, act.tk, act.wr, act.dn,
                 exp.n1, exp.n2, exp.n3, exp.n4, exp.tk, exp.wr, exp.dn);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifc.stop = 1'b0; ifc.clear = 1'b0; ifc.load = 1'b0;
    ifc.preset = '0; ifc.mode = 1'b0; ifc.lap = 1'b0;
    reset = 1'b1;
    model_reset();
    tick_cnt = 0; wrap_cnt = 0;
    #12;
    check("reset_outputs", int'({ifc.num1, ifc.num2, ifc.num3, ifc.num4, ifc.tick, ifc.wrapped, ifc.done}), 0);
    reset = 1'b0;

    // Up count from reset
    run(40);
    check("up40_display", disp(), 'h0010);
    check("up40_ticks", tick_cnt, 10);

    // Asynchronous reset between edges
    run(5);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("async_reset_num", disp(), 0);
    check("async_reset_flags", int'({ifc.tick, ifc.wrapped, ifc.done}), 0);
    reset = 1'b0;
    model_reset();

    // Rollover
    ifc.mode = 1'b0; ifc.load = 1'b1; ifc.preset = 16'h9599;
    cycle();
    ifc.load = 1'b0;
    wrap_cnt = 0;
    run(4);
    check("wrap_display", disp(), 0);
    check("wrap_pulses", wrap_cnt, 1);
    run(4);
    check("wrap_continues", disp(), 'h0001);

    // Count-down expiry
    ifc.mode = 1'b1; ifc.load = 1'b1; ifc.preset = 16'h0010;
    cycle();
    ifc.load = 1'b0;
    run(39);
    check("down_pre_expiry", int'({disp(), 3'(ifc.done)}), int'({16'h0001, 3'd0}));
    run(1);
    check("down_expired_num", disp(), 0);
    check("down_done", int'(ifc.done), 1);
    tick_cnt = 0;
    run(32);
    check("halt_no_ticks", tick_cnt, 0);
    check("halt_display", disp(), 0);
    check("halt_done_held", int'(ifc.done), 1);
    ifc.mode = 1'b0;
    cycle();
    check("done_cleared_by_mode", int'(ifc.done), 0);

    // Stop and resume
    ifc.clear = 1'b1;
    cycle();
    ifc.clear = 1'b0;
    run(2);
    ifc.stop = 1'b1;
    tick_cnt = 0;
    run(20);
    check("stop_display", disp(), 0);
    check("stop_ticks", tick_cnt, 0);
    ifc.stop = 1'b0;
    run(1);
    check("resume_first", int'(ifc.tick), 0);
    run(1);
    check("resume_tick", int'({disp(), 1'(ifc.tick)}), int'({16'h0001, 1'b1}));

    // Lap hold
    ifc.load = 1'b1; ifc.preset = 16'h0123;
    cycle();
    ifc.load = 1'b0; ifc.lap = 1'b1;
    cycle();
    ifc.lap = 1'b0;
    run(20);
    check("lap_frozen", disp(), 'h0123);
    ifc.lap = 1'b1;
    cycle();
    ifc.lap = 1'b0;
    check("lap_release", disp(), 'h0128);

    // Clear beats load and a coincident tick
    ifc.clear = 1'b1;
    cycle();
    ifc.clear = 1'b0;
    run(3);
    ifc.clear = 1'b1; ifc.load = 1'b1; ifc.preset = 16'h1234;
    cycle();
    ifc.clear = 1'b0; ifc.load = 1'b0;
    check("priority_display", disp(), 0);
    check("priority_no_tick", int'(ifc.tick), 0);

    // Preset clamp
    ifc.load = 1'b1; ifc.preset = 16'hF7F9;
    cycle();
    ifc.load = 1'b0;
    check("clamp_display", disp(), 'h9599);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      ifc.stop   = ($urandom_range(0, 9) == 0);
      ifc.clear  = ($urandom_range(0, 99) == 0);
      ifc.load   = ($urandom_range(0, 49) == 0);
      ifc.lap    = ($urandom_range(0, 29) == 0);
      ifc.preset = 16'($urandom);
      if ($urandom_range(0, 49) == 0) ifc.mode = ~ifc.mode;
      cycle();
    end
    ifc.stop = 1'b0; ifc.clear = 1'b0; ifc.load = 1'b0; ifc.lap = 1'b0;

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Single-clock stopwatch/timer core that replaces the rippled per-digit clocks with one `clk_base` domain, a parametrised tenth-second prescaler and clock-enabled BCD digit chain. It adds count-down mode with expiry, synchronous preset load, synchronous clear and lap (display-freeze) capture. It sits between the button-conditioning logic and the 7-segment display mux, and drives four BCD digits: minutes, tens of seconds, seconds and tenths.

## Interface
- `TICK_DIV`, default 250000: `clk_base` cycles per tenth-second tick. Must be ≥ 2.
- `DIV_W`, default 18: prescaler width. Requires 2^DIV_W ≥ TICK_DIV.
- `MIN_MAX`, default 9: highest minutes value. Range 1..9.

Ports:
- `clk_base`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `stop`  in  1: level. 1 freezes the prescaler and the count.
- `clear`  in  1: synchronous. Count, prescaler, `done`, lap state → 0.
- `load`  in  1: synchronous. Count ← clamped `preset`. Prescaler, `done` → 0.
- `preset`  in  16: BCD {min, sec tens, sec units, tenths}.
- `mode`  in  1: 0 = count up, 1 = count down.
- `lap`  in  1: single-cycle pulse that toggles display hold.
- `num4`  out  4: displayed tenths.
- `num3`  out  4: displayed seconds units.
- `num2`  out  4: displayed seconds tens.
- `num1`  out  4: displayed minutes.
- `tick`  out  1: one-cycle pulse when the count changes on a tick.
- `wrapped`  out  1: one-cycle pulse on count-up rollover.
- `done`  out  1: sticky count-down expiry flag.

## Operation
- Digit ranges:
  - tenths: 0–9
  - seconds units: 0–9
  - seconds tens: 0–5
  - minutes: 0–MIN_MAX
- Count register is always a valid BCD value.
- Prescaler `div_cnt`:
  - Advances each cycle when `stop`=0 and not halted.
  - At TICK_DIV-1 it returns to 0 and generates an internal tick.
  - When `stop`=1, `div_cnt` is held, not cleared. On resume, the partial period completes.
- Up (`mode`=0): increment tenths with carry chain.
  - MIN_MAX:5:9:9 → 0:0:0:0, `wrapped`=1 for that cycle, counting continues.
- Down (`mode`=1): decrement with borrow chain.
  - A tick that yields 0:0:0:0 sets `done`.
  - While count = 0:0:0:0 in down mode: halted. Prescaler frozen, no underflow, `done` set if not already.
- `done` clears on `reset`, `clear`, `load`, or `mode`=0.
- `mode` changes take effect at the next tick. The count is not altered by a mode change.
- Priority, highest first: `reset` > `clear` > `load` > tick.
  - `clear` or `load` in the same cycle as a tick suppresses the tick, `tick` and `wrapped`.
- Preset clamp, per digit:
  - tenths > 9 → 9
  - units > 9 → 9
  - tens > 5 → 5
  - min > MIN_MAX → MIN_MAX
- Lap:
  - `lap` while not holding: capture the pre-edge count into the lap register and set hold.
  - `lap` while holding: release hold.
  - `num*` = hold ? lap register : live count.
  - The live count keeps running during hold.
  - `clear` releases hold and zeroes the lap register.
  - `load` does not affect lap state.

## Timing
- Reset values: all `num*` = 0, `tick`=0, `wrapped`=0, `done`=0, hold=0, `div_cnt`=0.
  - Outputs reach these values asynchronously, with no clock edge required.
- Tick period is exactly TICK_DIV cycles of un-stopped, un-halted running.
- The count updates on the edge where `div_cnt`=TICK_DIV-1.
  - `tick` and `wrapped` are high during the following cycle, coincident with the new count on `num*` (if not holding).
- `done` rises in the same cycle the count first shows 0:0:0:0.
- `load` and `clear` are visible on `num*` in the cycle after the edge (1-cycle latency). Same for hold changes from `lap`.
- `lap` coincident with a tick captures the pre-tick value.

## Test plan
- Bench parameters: TICK_DIV=4, MIN_MAX=9.
- Up count and reset: from reset, run 40 cycles → `num1..num4` = 0,0,1,0 with 10 `tick` pulses. Assert `reset` between edges → all outputs 0 immediately.
- Wrap: load 16'h9599, `mode`=0, run 4 cycles → 0:0:0:0, `wrapped` high exactly 1 cycle, counting continues.
- Count-down expiry: load 16'h0010, `mode`=1, run 40 cycles → 0:0:0:0 with `done`=1 on that cycle. Run 32 more cycles → still 0:0:0:0, no `tick`, `done` held. Set `mode`=0 → `done`=0.
- Stop/resume: `stop`=1 after 2 prescaler cycles, hold 20 cycles → count and `div_cnt` unchanged. Release → next tick after exactly 2 more cycles.
- Lap: reach 0:1:2:3, pulse `lap`, run 20 cycles → `num*` stays 0,1,2,3. Pulse `lap` again → `num*` = 0,1,2,8 next cycle.
- Priority and clamp:
  - `clear` with `load` and a tick in the same cycle → 0:0:0:0, no `tick`.
  - Load 16'hF7F9 → 9:5:9:9.
